dpram_fifo_ctrl: RTL
====================

// Module: dpram_fifo_ctrl
// PURPOSE
//  Synchronous FIFO controller that drives a dual-port dpram instance.
//  - Port A is the write port; port B is the read port.
//  - Producer side uses a valid/ready handshake; consumer side is first-word-fall-through
//    (FWFT) with a 2-entry output skid, so it can sustain 1 word/cycle.
//  - Sits between a bus/stream producer (e.g. slot write path) and its consumer.
// PARAMETERS
//  ADDR_W  8  dpram address width; RAM depth DEPTH = 2**ADDR_W
//  DATA_W  8  word width; must match dpram width_a
// PORTS
//  clock       in   1         single clock; also drives dpram clock_a and clock_b
//  reset       in   1         asynchronous, active-high
//  flush       in   1         synchronous clear of all contents
//  wr_valid    in   1         producer has a word
//  wr_ready    out  1         FIFO accepts a word this cycle
//  wr_data     in   DATA_W    producer word
//  rd_valid    out  1         rd_data holds the head word
//  rd_ready    in   1         consumer takes the head word
//  rd_data     out  DATA_W    head word (FWFT)
//  level       out  ADDR_W+2  words held: RAM + in-flight read + skid
//  ram_addr_a  out  ADDR_W    to dpram address_a (write pointer)
//  ram_data_a  out  DATA_W    to dpram data_a
//  ram_wren_a  out  1         to dpram wren_a; rden_a is tied 0 by the parent
//  ram_addr_b  out  ADDR_W    to dpram address_b (read pointer)
//  ram_rden_b  out  1         to dpram rden_b; wren_b is tied 0 by the parent
//  ram_q_b     in   DATA_W    from dpram q_b; valid the cycle after ram_rden_b
// BEHAVIOUR
//  Reset and flush values:
//  - Async reset or flush clears: wptr, rptr, ram_cnt, pend, skid_cnt = 0.
//  - Outputs after reset/flush: wr_ready=1, rd_valid=0, level=0, ram_wren_a=0, ram_rden_b=0.
//  - rd_data is undefined while rd_valid=0; the bench does not check it.
//  - flush has priority over all same-cycle handshakes, which are dropped.
//  - Reset asserted mid-transfer discards all contents; no partial word survives.
//  Write side:
//  - wr_ready = (ram_cnt != DEPTH).
//  - Accept = wr_valid & wr_ready. Then ram_wren_a=1, ram_addr_a=wptr, ram_data_a=wr_data
//    (combinational), and wptr increments modulo DEPTH (natural wrap).
//  Read fetch:
//  - Issue when ram_cnt_eff != 0 and (skid_cnt + pend - pop) < 2.
//  - ram_cnt_eff excludes a word written in the same cycle, so port B never reads an
//    address in the cycle it is written.
//  - On issue: ram_rden_b=1, ram_addr_b=rptr, rptr++ (mod DEPTH), ram_cnt--, pend=1.
//  - The cycle after an issue, ram_q_b is pushed into the skid (FIFO order) and pend clears.
//  Skid (2 entries):
//  - rd_valid = (skid_cnt != 0); rd_data = skid head.
//  - pop = rd_valid & rd_ready.
//  - Push and pop in the same cycle are both legal.
//  Counters:
//  - ram_cnt is ADDR_W+1 bits; simultaneous accept + issue leaves it unchanged.
//  - level = ram_cnt + pend + skid_cnt; maximum is DEPTH+2.
//  Latency and throughput:
//  - Empty FIFO: word accepted at edge N gives rd_valid=1 after edge N+3.
//  - Steady state: 1 word/cycle with rd_ready held high.
// STRUCTURE
//  - Shared package fifo_pkg: typedef ptr_t [ADDR_W-1:0] and localparam SKID_DEPTH=2.
//  - Sub-module fifo_skid2: 2-entry FWFT register buffer with push/pop/count.
//  - Pointers and counters stay in the top-level module.
//  - dpram is instantiated by the parent, not inside this block.
// TESTING (ADDR_W=4, DEPTH=16)
//  1. Reset, then write 0xA5 with rd_ready=0 -> rd_valid rises 3 cycles after accept;
//     rd_data=0xA5; level=1.
//  2. Write 0x00..0x11 (18 words) with rd_ready=0 -> wr_ready drops after the 18th
//     accept; level=18.
//  3. From the full state of test 2, hold rd_ready=1 -> data 0x00..0x11 in order at
//     1 word/cycle; wr_ready rises after the first pop.
//  4. Stream 40 words with wr_valid=1 and rd_ready=1 -> both pointers wrap twice;
//     output order is intact; no gaps after the 3-cycle fill.
//  5. Fill 5 words, then pulse flush together with wr_valid and rd_ready -> next cycle
//     level=0, rd_valid=0, and the flush-cycle word is not stored.
//  6. Assert reset with pend=1 -> outputs are at reset values immediately (async);
//     after release the stale ram_q_b is not pushed.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared types and constants for the dpram FIFO controller and its skid buffer.
//   ptr_t       RAM pointer at the default address width (sets ADDR_W's default)
//   SKID_DEPTH  number of output skid entries behind the RAM read port
//   skid_cnt_t  occupancy count of the skid buffer (0..SKID_DEPTH)
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int ADDR_W_DEFAULT = 8;
  localparam int SKID_DEPTH     = 2;

  typedef logic [ADDR_W_DEFAULT-1:0]          ptr_t;
  typedef logic [$clog2(SKID_DEPTH+1)-1:0]    skid_cnt_t;

endpackage

// File: rtl/fifo_skid2.sv
// -----------------------------------------------------------------------------
// fifo_skid2
// Two-entry first-word-fall-through register buffer. Entry 0 is always the
// head, so head is valid whenever count != 0. Push and pop in the same cycle
// are both honoured; flush empties the buffer and drops that cycle's push/pop.
// Ports:
//   clock, reset   clock and asynchronous active-high reset
//   flush          synchronous clear of the occupancy
//   push/push_data append a word at the tail
//   pop            remove the head word
//   count          words held (0..2)
//   head           head word, meaningful only while count != 0
// -----------------------------------------------------------------------------
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output skid_cnt_t         count,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  skid_cnt_t         cnt_q, cnt_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    if (flush) begin
      cnt_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == '0) ent0_d = push_data;
          else             ent1_d = push_data;
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_d = ent1_q;
          cnt_d  = cnt_q - 2'd1;
        end
        2'b11: begin
          // Count is unchanged; the pushed word lands behind whatever remains.
          if (cnt_q == 2'd1) begin
            ent0_d = push_data;
          end else begin
            ent0_d = ent1_q;
            ent1_d = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // NOTE: data entries are deliberately not reset; the count alone decides
  // validity, and leaving storage unreset keeps it plain registers.
  always_ff @(posedge clock) begin
    ent0_q <= ent0_d;
    ent1_q <= ent1_d;
  end

  assign count = cnt_q;
  assign head  = ent0_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
// Synchronous FIFO controller around an external dual-port RAM. Port A writes
// (valid/ready producer), port B reads into a 2-entry FWFT skid so the consumer
// sees 1 word/cycle.
// Ports:
//   clock, reset, flush    clock, async active-high reset, sync clear
//   wr_valid/ready/data    producer handshake
//   rd_valid/ready/data    FWFT consumer handshake
//   level                  words held: RAM + in-flight read + skid
//   ram_addr_a/data_a/wren_a  RAM write port
//   ram_addr_b/rden_b/q_b     RAM read port (q_b valid the cycle after rden_b)
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = $bits(ptr_t),
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W+1:0] level,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic              ram_wren_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_rden_b,
  input  logic [DATA_W-1:0] ram_q_b
);

  localparam int              DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
  logic              pend_q, pend_d;

  skid_cnt_t         skid_cnt;
  logic [DATA_W-1:0] skid_head;
  logic              accept, issue, pop;
  logic [2:0]        skid_after;

  always_comb begin
    wr_ready = (ram_cnt_q != DEPTH_CNT);
    rd_valid = (skid_cnt != '0);
    // Flush wins over both handshakes in the same cycle.
    accept   = wr_valid & wr_ready & ~flush;
    pop      = rd_valid & rd_ready & ~flush;
    // Skid occupancy once this cycle's pop and last cycle's fetch settle;
    // a new fetch is only allowed if its word will still find a free entry.
    skid_after = 3'(skid_cnt) + 3'(pend_q) - 3'(pop);
    // The registered count excludes this cycle's write, so port B never
    // reads the address port A is writing.
    issue    = (ram_cnt_q != '0) && (skid_after < 3'(SKID_DEPTH)) && !flush;

    wptr_d    = accept ? wptr_q + 1'b1 : wptr_q;
    rptr_d    = issue  ? rptr_q + 1'b1 : rptr_q;
    ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(issue);
    pend_d    = issue;
    if (flush) begin
      wptr_d    = '0;
      rptr_d    = '0;
      ram_cnt_d = '0;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      ram_cnt_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ram_cnt_q <= ram_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // The word fetched last cycle is on ram_q_b now; pend_q marks it.
  fifo_skid2 #(.DATA_W(DATA_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (pend_q),
    .push_data (ram_q_b),
    .pop       (pop),
    .count     (skid_cnt),
    .head      (skid_head)
  );

  assign rd_data    = skid_head;
  assign level      = (ADDR_W+2)'(ram_cnt_q) + (ADDR_W+2)'(pend_q) + (ADDR_W+2)'(skid_cnt);
  assign ram_addr_a = wptr_q;
  assign ram_data_a = wr_data;
  assign ram_wren_a = accept;
  assign ram_addr_b = rptr_q;
  assign ram_rden_b = issue;

endmodule
